// File: rtl/strobe_scheduler.sv
// strobe_scheduler
//   Shares one single-cycle access strobe among N_REQ requesters. A programmable divider
//   produces a slot tick every (div+1) enabled cycles; on each tick one pending requester
//   receives a one-cycle one-hot grant, chosen round-robin.
//
// Build option:
//   STRB_SCHED_FIXED_PRIO_EN  when defined, the winner is the lowest-index set req bit.
//                             The round-robin pointer is still maintained but not used.
//                             Ports, timing and reset values are identical in both builds.
//
// Ports:
//   clk        in   1      fast system clock, posedge
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      enable; low freezes the divider and suppresses ticks/grants
//   hold       in   1      ticks continue, grants suppressed
//   div        in   DIV_W  slot period minus one, sampled only on slot edges
//   req        in   N_REQ  level requests
//   tick       out  1      one-cycle slot pulse
//   gnt        out  N_REQ  one-hot grant pulse, coincident with tick
//   gnt_valid  out  1      OR of gnt
//   gnt_idx    out  IDX_W  index of the granted requester, holds between grants
//
// Operating modes are implicit in the counter: idle (en=0), counting (cnt<div_q) and
// slot (cnt==div_q). No separate state register is needed.

module strobe_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  input  logic [N_REQ-1:0] req,
  output logic             tick,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam logic [IDX_W-1:0] LastRst = IDX_W'(N_REQ - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic             slot;
  logic [IDX_W-1:0] win_idx;

  // Winner selection. Only meaningful when |req; the grant path checks that separately.
`ifdef STRB_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_idx = '0;
    // Descending scan so the lowest set index is the final assignment.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IDX_W'(i);
    end
  end
`else
  always_comb begin
    logic                found;
    int unsigned         cand;
    logic [IDX_W-1:0]    cand_idx;
    win_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Search starts one past the last winner and wraps; i=N_REQ revisits the last winner.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand     = (int'(last_q) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end
`endif

  assign slot = en && (cnt_q == div_q);

  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    tick_d      = 1'b0;
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;

    if (slot) begin
      cnt_d  = '0;
      // New period length applies from the period that starts after this tick.
      div_d  = div;
      tick_d = 1'b1;
      if (!hold && (|req)) begin
        gnt_d       = N_REQ'(1) << win_idx;
        gnt_valid_d = 1'b1;
        gnt_idx_d   = win_idx;
        last_d      = win_idx;
      end
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      div_q       <= '0;
      tick_q      <= 1'b0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      last_q      <= LastRst;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
    end
  end

  assign tick      = tick_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_strobe_scheduler.sv
module tb_strobe_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       hold;
  logic [7:0] div;
  logic [3:0] req;
  logic       tick;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_idx = 2'd0;
  logic [3:0] rr_seq [5];

  strobe_scheduler #(
    .N_REQ(4),
    .DIV_W(8),
    .IDX_W(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .hold     (hold),
    .div      (div),
    .req      (req),
    .tick     (tick),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic check_outs(input string tag, input logic tick_e, input logic [3:0] gnt_e);
    if (gnt_e != 4'b0000) begin
      for (int b = 0; b < 4; b++) if (gnt_e[b]) exp_idx = 2'(b);
    end
    total++;
    assert (tick === tick_e) else begin
      bad++;
      $error("FAIL %s tick got %b exp %b", tag, tick, tick_e);
    end
    total++;
    assert (gnt === gnt_e) else begin
      bad++;
      $error("FAIL %s gnt got %b exp %b", tag, gnt, gnt_e);
    end
    total++;
    assert (gnt_valid === (|gnt_e)) else begin
      bad++;
      $error("FAIL %s gnt_valid got %b exp %b", tag, gnt_valid, |gnt_e);
    end
    total++;
    assert (gnt_idx === exp_idx) else begin
      bad++;
      $error("FAIL %s gnt_idx got %0d exp %0d", tag, gnt_idx, exp_idx);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic cyc(input string tag, input logic tick_e, input logic [3:0] gnt_e);
    @(posedge clk);
    #1;
    check_outs(tag, tick_e, gnt_e);
  endtask

  initial begin
    rr_seq[0] = 4'b0001;
    rr_seq[1] = 4'b0010;
    rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000;
    rr_seq[4] = 4'b0001;

    rst_n = 1'b0;
    en    = 1'b0;
    hold  = 1'b0;
    div   = 8'd3;
    req   = 4'b0000;
    #1;
    check_outs("reset", 1'b0, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

`ifdef STRB_SCHED_FIXED_PRIO_EN
    div = 8'd0;
    req = 4'b1111;
    // div_q=0 after reset: every enabled cycle is a slot.
    for (int i = 0; i < 4; i++) cyc("fp_all", 1'b1, 4'b0001);
    req = 4'b1100;
    for (int i = 0; i < 4; i++) cyc("fp_hi", 1'b1, 4'b0100);
`else
    // First enabled cycle ticks (div_q=0), then period 4.
    for (int i = 0; i < 9; i++) cyc("idle_ticks", (i % 4) == 0, 4'b0000);

    // All requesting: round-robin starting at 0 because last resets to 3.
    req = 4'b1111;
    for (int i = 1; i <= 20; i++) begin
      if ((i % 4) == 0) cyc("rr_all", 1'b1, rr_seq[i/4 - 1]);
      else              cyc("rr_all", 1'b0, 4'b0000);
    end

    // div=1 takes effect after the next tick (still period 4 here). last=0.
    div = 8'd1;
    req = 4'b1010;
    cyc("div1_a", 1'b0, 4'b0000);
    cyc("div1_a", 1'b0, 4'b0000);
    cyc("div1_a", 1'b0, 4'b0000);
    cyc("div1_a", 1'b1, 4'b0010);
    cyc("div1_b", 1'b0, 4'b0000);
    cyc("div1_b", 1'b1, 4'b1000);
    cyc("div1_b", 1'b0, 4'b0000);
    cyc("div1_b", 1'b1, 4'b0010);
    cyc("div1_b", 1'b0, 4'b0000);
    cyc("div1_b", 1'b1, 4'b1000);

    // Dropped requester is never served again.
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cyc("drop_req", 1'b0, 4'b0000);
      cyc("drop_req", 1'b1, 4'b0010);
    end

    // div=0: back-to-back slots once the current period ends. last=1.
    div = 8'd0;
    req = 4'b1111;
    cyc("div0", 1'b0, 4'b0000);
    cyc("div0", 1'b1, 4'b0100);
    cyc("div0", 1'b1, 4'b1000);
    cyc("div0", 1'b1, 4'b0001);
    // div=2 mid-run: one more 1-cycle period, then period 3.
    div = 8'd2;
    cyc("div2", 1'b1, 4'b0010);
    cyc("div2", 1'b0, 4'b0000);
    cyc("div2", 1'b0, 4'b0000);
    cyc("div2", 1'b1, 4'b0100);

    // hold for two ticks: ticks continue, no grant, pointer untouched.
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc("hold", 1'b0, 4'b0000);
      cyc("hold", 1'b0, 4'b0000);
      cyc("hold", 1'b1, 4'b0000);
    end
    hold = 1'b0;
    cyc("post_hold", 1'b0, 4'b0000);
    cyc("post_hold", 1'b0, 4'b0000);
    cyc("post_hold", 1'b1, 4'b1000);

    // Asynchronous reset while gnt is high.
    #2;
    rst_n = 1'b0;
    #1;
    exp_idx = 2'd0;
    check_outs("async_rst", 1'b0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 4'b0100;
    div   = 8'd3;
    cyc("after_rst", 1'b1, 4'b0100);
    cyc("after_rst", 1'b0, 4'b0000);
    cyc("after_rst", 1'b0, 4'b0000);
    cyc("after_rst", 1'b0, 4'b0000);
    cyc("after_rst", 1'b1, 4'b0100);

    // en low freezes the counter (cnt=1 here), then counting resumes.
    cyc("en_pause", 1'b0, 4'b0000);
    en = 1'b0;
    for (int i = 0; i < 3; i++) cyc("en_low", 1'b0, 4'b0000);
    en = 1'b1;
    cyc("en_resume", 1'b0, 4'b0000);
    cyc("en_resume", 1'b0, 4'b0000);
    cyc("en_resume", 1'b1, 4'b0100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
